// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready bitwise logic unit with result flags and handshake counter
module logic_unit_pipe #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    // Stage 1: captured operands and operation
    logic             r_s1_v;
    logic [N-1:0]     r_s1_a;
    logic [N-1:0]     r_s1_b;
    logic [2:0]       r_s1_op;

    // Stage 2: registered result and flags
    logic             r_s2_v;
    logic [N-1:0]     r_out;
    logic             r_zero;
    logic             r_ones;
    logic             r_parity;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [N-1:0]     w_res;
    logic             w_zero;
    logic             w_ones;
    logic             w_parity;

    // A stage may advance when it is empty or the stage after it is moving
    assign w_s2_adv = !r_s2_v || out_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_v;
    assign out       = r_out;
    assign zero      = r_zero;
    assign ones      = r_ones;
    assign parity    = r_parity;
    assign op_count  = r_cnt;

    // Bitwise result of the operation held in stage 1
    always_comb begin
        w_res = '0;
        case (r_s1_op)
            3'b000:  w_res = ~r_s1_a;
            3'b001:  w_res = r_s1_a & r_s1_b;
            3'b010:  w_res = r_s1_a | r_s1_b;
            3'b011:  w_res = r_s1_a ^ r_s1_b;
            3'b100:  w_res = ~(r_s1_a & r_s1_b);
            3'b101:  w_res = ~(r_s1_a | r_s1_b);
            3'b110:  w_res = ~(r_s1_a ^ r_s1_b);
            default: w_res = r_s1_a;
        endcase
    end

    assign w_zero   = (w_res == '0);
    assign w_ones   = &w_res;
    assign w_parity = ^w_res;

    // Stage 1 register: load on input handshake, empty when advancing without one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v  <= 1'b0;
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_op <= '0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_a  <= a;
                r_s1_b  <= b;
                r_s1_op <= op;
            end
        end
    end

    // Stage 2 register: result and flags move together so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v   <= 1'b0;
            r_out    <= '0;
            r_zero   <= 1'b0;
            r_ones   <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v   <= r_s1_v;
            r_out    <= w_res;
            r_zero   <= w_zero;
            r_ones   <= w_ones;
            r_parity <= w_parity;
        end
    end

    // Wrapping count of completed output handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_s2_v && out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe with queue reference model
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out;
    logic       zero;
    logic       ones;
    logic       parity;
    logic [7:0] op_count;

    logic       c2_in_valid;
    logic       c2_in_ready;
    logic       c2_out_valid;
    logic       c2_out_ready;
    logic [3:0] c2_out;
    logic       c2_zero;
    logic       c2_ones;
    logic       c2_parity;
    logic [1:0] c2_op_count;

    int n_checks = 0;
    int n_errors = 0;

    logic_unit_pipe #(.N(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .ones(ones), .parity(parity), .op_count(op_count)
    );

    logic_unit_pipe #(.N(4), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(c2_in_valid), .in_ready(c2_in_ready),
        .a(4'h5), .b(4'h3), .op(3'd1), .out_valid(c2_out_valid), .out_ready(c2_out_ready),
        .out(c2_out), .zero(c2_zero), .ones(c2_ones), .parity(c2_parity), .op_count(c2_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: result of an op from the operation table
    function automatic logic [3:0] ref_res(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & y;
            3'd2:    return x | y;
            3'd3:    return x ^ y;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            3'd6:    return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    // Reference flags {zero, ones, parity} from plain arithmetic on the result value
    function automatic logic [2:0] ref_flg(input logic [3:0] r);
        int pop;
        pop = $countones(r);
        return {r == 4'd0, r == 4'd15, (pop % 2) == 1};
    endfunction

    typedef struct {
        logic [3:0] res;
        logic [2:0] flg;
        int         cyc;
    } beat_t;

    beat_t      q[$];
    int         exp_cnt = 0;
    int         cyc = 0;
    bit         lat_chk = 1'b0;
    bit         stall = 1'b0;
    logic [3:0] h_out;
    logic [2:0] h_flg;

    // Scoreboard: every negedge, compare DUT against the queue model
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            exp_cnt = 0;
            stall   = 1'b0;
        end else begin
            chk(op_count == 8'(exp_cnt), "op_count", 32'(op_count), 32'(8'(exp_cnt)));
            if (stall)
                chk(out_valid && out == h_out && {zero, ones, parity} == h_flg, "hold",
                    32'({out_valid, out, zero, ones, parity}), 32'({1'b1, h_out, h_flg}));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "extra_beat", 32'(out), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk(out == e.res && {zero, ones, parity} == e.flg, "data",
                        32'({out, zero, ones, parity}), 32'({e.res, e.flg}));
                    if (lat_chk)
                        chk(cyc - e.cyc == 2, "latency", 32'(cyc - e.cyc), 32'(2));
                end
                exp_cnt++;
            end
            if (in_valid && in_ready) begin
                e.res = ref_res(a, b, op);
                e.flg = ref_flg(e.res);
                e.cyc = cyc;
                q.push_back(e);
            end
            stall = out_valid && !out_ready;
            h_out = out;
            h_flg = {zero, ones, parity};
        end
    end

    // Wait for the next delivered beat and compare it with a literal
    task automatic expect_beat(input logic [3:0] v, input bit cf, input logic [2:0] f, input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk(out_valid && out == v, nm, 32'({out_valid, out}), 32'({1'b1, v}));
        if (cf)
            chk({zero, ones, parity} == f, {nm, "_flags"}, 32'({zero, ones, parity}), 32'(f));
    endtask

    initial begin
        logic [3:0] lit_ops [8];
        logic [1:0] wrap_seq [5];
        logic [3:0] held;
        int         k;
        int         sent;
        int         budget;

        lit_ops = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100};
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        c2_in_valid = 1'b0; c2_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(out_valid == 1'b0 && in_ready == 1'b1, "reset_vr", 32'({out_valid, in_ready}), 32'(2'b01));
        chk(out == 4'd0 && {zero, ones, parity} == 3'd0, "reset_out", 32'({out, zero, ones, parity}), 32'(0));
        chk(op_count == 8'd0, "reset_cnt", 32'(op_count), 32'(0));
        rst_n = 1'b1;

        // Counter wrap on the CNT_W=2 instance
        fork
            begin
                c2_in_valid = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                c2_in_valid = 1'b0;
            end
            begin
                bit pend;
                int idx;
                pend = 1'b0;
                idx  = 0;
                for (int t = 0; t < 20 && idx < 5; t++) begin
                    @(negedge clk);
                    if (pend) begin
                        chk(c2_op_count == wrap_seq[idx], "wrap_cnt", 32'(c2_op_count), 32'(wrap_seq[idx]));
                        idx++;
                    end
                    pend = c2_out_valid && c2_out_ready;
                end
                chk(idx == 5, "wrap_done", 32'(idx), 32'(5));
            end
        join

        // All eight ops back to back, latency checked by the scoreboard
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = 4'b1100; b = 4'b1010; op = 3'(i); in_valid = 1'b1;
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 8; j++)
                    expect_beat(lit_ops[j], 1'b0, 3'd0, "op_result");
            end
        join
        repeat (3) @(negedge clk);
        chk(op_count == 8'd8, "op_count_8", 32'(op_count), 32'(8));

        // Flag corner cases
        @(posedge clk);
        #1;
        fork
            begin
                a = 4'b0000; op = 3'd7; in_valid = 1'b1;
                @(posedge clk); #1;
                a = 4'b0000; op = 3'd0;
                @(posedge clk); #1;
                a = 4'b0111; op = 3'd7;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                expect_beat(4'b0000, 1'b1, 3'b100, "flag_zero");
                expect_beat(4'b1111, 1'b1, 3'b010, "flag_ones");
                expect_beat(4'b0111, 1'b1, 3'b001, "flag_par");
            end
        join
        lat_chk = 1'b0;

        // Backpressure: only two beats fit while out_ready is low
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            a = 4'(k + 1); b = 4'd0; op = 3'd7; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk);
            #1;
        end
        chk(k == 2, "bp_accepted", 32'(k), 32'(2));
        @(negedge clk);
        chk(in_ready == 1'b0 && out_valid == 1'b1, "bp_full", 32'({in_ready, out_valid}), 32'(2'b01));
        held = out;
        repeat (3) @(negedge clk);
        chk(out == held && out == 4'd1, "bp_stable", 32'(out), 32'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        fork
            begin
                while (k < 5) begin
                    a = 4'(k + 1); in_valid = 1'b1;
                    @(negedge clk);
                    if (in_ready) k++;
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk(out_valid && out == 4'(j + 1), "bp_order", 32'({out_valid, out}), 32'({1'b1, 4'(j + 1)}));
                end
            end
        join

        // Random traffic against the queue model
        sent = 0;
        budget = 0;
        while (sent < 1000 && budget < 20000) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            a  = 4'($urandom);
            b  = 4'($urandom);
            op = 3'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            budget++;
        end
        chk(sent == 1000, "random_sent", 32'(sent), 32'(1000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk(q.size() == 0, "drain_empty", 32'(q.size()), 32'(0));
        chk(op_count == 8'(exp_cnt) && exp_cnt >= 1000, "random_count", 32'(op_count), 32'(8'(exp_cnt)));

        // Asynchronous reset with both stages full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = 4'h9; op = 3'd3; b = 4'h6; in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk(in_ready == 1'b0 && out_valid == 1'b1, "pre_reset_full", 32'({in_ready, out_valid}), 32'(2'b01));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0 && in_ready == 1'b1, "async_vr", 32'({out_valid, in_ready}), 32'(2'b01));
        chk(out == 4'd0 && {zero, ones, parity} == 3'd0, "async_out", 32'({out, zero, ones, parity}), 32'(0));
        chk(op_count == 8'd0, "async_cnt", 32'(op_count), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        fork
            begin
                a = 4'b0101; op = 3'd0; in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            expect_beat(4'b1010, 1'b1, 3'b000, "post_reset");
        join
        repeat (2) @(negedge clk);
        chk(op_count == 8'd1, "post_reset_cnt", 32'(op_count), 32'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
